// File: rtl/ram_if_pkg.sv
// rtl/ram_if_pkg.sv - shared size codes, FSM encoding and lane helpers for the data-side RAM path
package ram_if_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [3:0] LANE_NONE    = 4'b0000;
    localparam logic [3:0] LANE_BYTE0   = 4'b0001;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_ALL     = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Byte-lane enables for a legal access of the given size at byte offset off.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: lane_sel = LANE_BYTE0 << off;
            SIZE_HALF: lane_sel = off[1] ? LANE_HALF_HI : LANE_HALF_LO;
            default:   lane_sel = LANE_ALL;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it could land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: lane_wdata = {4{wdata[7:0]}};
            SIZE_HALF: lane_wdata = {2{wdata[15:0]}};
            default:   lane_wdata = wdata;
        endcase
    endfunction

endpackage

// File: rtl/ram_master_if.sv
// rtl/ram_master_if.sv - core request/response handshake between a load/store unit and ram_master
interface ram_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/ram_lane_ext.sv
// rtl/ram_lane_ext.sv - extract a byte/half/word lane from a RAM word and sign- or zero-extend it
module ram_lane_ext
    import ram_if_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane, then extend from its top bit unless zero-extension is requested.
    always_comb begin
        byte_lane = 8'(word >> {off, 3'b000});
        half_lane = off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SIZE_HALF: data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            SIZE_WORD: data = word;
            default:   data = 32'd0;
        endcase
    end

endmodule

// File: rtl/ram_master.sv
// rtl/ram_master.sv - single-outstanding load/store initiator for the byte-lane data RAM
module ram_master
    import ram_if_pkg::*;
#(
    parameter int RAM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    ram_master_if.slave core,
    output logic        ram_wr_en,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_addr_sel,
    output logic [31:0] ram_wr_data,
    input  logic [31:0] ram_data_in
);

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;

    logic        misaligned;
    logic        req_err;
    logic [31:0] load_data;

    // Reject illegal sizes, unaligned halves/words and anything past the decoded RAM.
    always_comb begin
        case (core.req_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = core.req_addr[0];
            SIZE_WORD: misaligned = |core.req_addr[1:0];
            default:   misaligned = 1'b1;
        endcase
        req_err = misaligned | (core.req_addr >= 32'(RAM_BYTES));
    end

    ram_lane_ext u_lane_ext (
        .word        (ram_data_in),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    // Request FSM; every core and RAM output is a register so RAM strobes are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            we_q            <= 1'b0;
            size_q          <= SIZE_BYTE;
            uns_q           <= 1'b0;
            off_q           <= 2'd0;
            core.req_ready  <= 1'b1;
            core.resp_valid <= 1'b0;
            core.resp_rdata <= 32'd0;
            core.resp_err   <= 1'b0;
            ram_wr_en       <= 1'b0;
            ram_addr        <= 32'd0;
            ram_addr_sel    <= LANE_NONE;
            ram_wr_data     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (core.req_valid) begin
                        we_q           <= core.req_we;
                        size_q         <= core.req_size;
                        uns_q          <= core.req_unsigned;
                        off_q          <= core.req_addr[1:0];
                        core.req_ready <= 1'b0;
                        if (req_err) begin
                            // Errors skip the RAM entirely and answer one cycle after acceptance.
                            state           <= RESP;
                            core.resp_valid <= 1'b1;
                            core.resp_err   <= 1'b1;
                            core.resp_rdata <= 32'd0;
                        end else begin
                            state        <= ACCESS;
                            ram_wr_en    <= core.req_we;
                            ram_addr     <= {core.req_addr[31:2], 2'b00};
                            ram_addr_sel <= lane_sel(core.req_size, core.req_addr[1:0]);
                            ram_wr_data  <= lane_wdata(core.req_size, core.req_wdata);
                        end
                    end
                end
                ACCESS: begin
                    // Store commits and load data is captured on this same edge.
                    state           <= RESP;
                    ram_wr_en       <= 1'b0;
                    ram_addr        <= 32'd0;
                    ram_addr_sel    <= LANE_NONE;
                    ram_wr_data     <= 32'd0;
                    core.resp_valid <= 1'b1;
                    core.resp_err   <= 1'b0;
                    core.resp_rdata <= we_q ? 32'd0 : load_data;
                end
                RESP: begin
                    if (core.resp_ready) begin
                        state           <= IDLE;
                        core.req_ready  <= 1'b1;
                        core.resp_valid <= 1'b0;
                        core.resp_err   <= 1'b0;
                        core.resp_rdata <= 32'd0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    core.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - directed self-checking bench for ram_master with a byte-lane RAM model
module tb_ram_master;

    logic        clk;
    logic        rst;
    logic        ram_wr_en;
    logic [31:0] ram_addr;
    logic [3:0]  ram_addr_sel;
    logic [31:0] ram_wr_data;
    logic [31:0] ram_data_in;
    logic [7:0]  mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    ram_master_if bus ();

    ram_master #(.RAM_BYTES(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .core         (bus.slave),
        .ram_wr_en    (ram_wr_en),
        .ram_addr     (ram_addr),
        .ram_addr_sel (ram_addr_sel),
        .ram_wr_data  (ram_wr_data),
        .ram_data_in  (ram_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-lane RAM: lane-masked write at the clock edge, combinational read that is 0 while writing.
    always @(posedge clk) begin
        if (ram_wr_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_addr_sel[i]) mem[{ram_addr[7:2], 2'(i)}] <= ram_wr_data[8*i +: 8];
        end
    end

    always_comb begin
        ram_data_in = 32'd0;
        if (!ram_wr_en)
            ram_data_in = {mem[{ram_addr[7:2], 2'd3}], mem[{ram_addr[7:2], 2'd2}],
                           mem[{ram_addr[7:2], 2'd1}], mem[{ram_addr[7:2], 2'd0}]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transaction; stall = cycles resp_ready is held low once the response is up.
    task automatic txn(input string tag, input bit we, input bit [1:0] size, input bit uns,
                       input bit [31:0] addr, input bit [31:0] wdata, input bit exp_err,
                       input bit [31:0] exp_rdata, input bit [3:0] exp_sel,
                       input bit [31:0] exp_wd, input int stall);
        int waitc = 0;
        @(negedge clk);
        while (!bus.req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.resp_ready   = (stall == 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (exp_err) begin
            check({tag, "/err_wr_en"}, 32'(ram_wr_en), 32'd0);
            check({tag, "/err_sel"}, 32'(ram_addr_sel), 32'd0);
        end else begin
            check({tag, "/wr_en"}, 32'(ram_wr_en), 32'(we));
            check({tag, "/sel"}, 32'(ram_addr_sel), 32'(exp_sel));
            check({tag, "/addr"}, ram_addr, {addr[31:2], 2'b00});
            check({tag, "/wr_data"}, ram_wr_data, exp_wd);
            check({tag, "/early_valid"}, 32'(bus.resp_valid), 32'd0);
            @(negedge clk);
            check({tag, "/ram_idle"}, {ram_addr_sel, 3'd0, ram_wr_en, ram_addr[23:0]}, 32'd0);
        end
        check({tag, "/resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "/resp_err"}, 32'(bus.resp_err), 32'(exp_err));
        check({tag, "/resp_rdata"}, bus.resp_rdata, exp_rdata);
        check({tag, "/busy"}, 32'(bus.req_ready), 32'd0);
        for (int i = 1; i <= stall; i++) begin
            @(negedge clk);
            check({tag, "/stall_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "/stall_rdata"}, bus.resp_rdata, exp_rdata);
            check({tag, "/stall_err"}, 32'(bus.resp_err), 32'(exp_err));
            check({tag, "/stall_busy"}, 32'(bus.req_ready), 32'd0);
            if (i == stall) bus.resp_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "/done_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "/done_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.resp_ready   = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst/req_ready", 32'(bus.req_ready), 32'd1);
        check("rst/resp", {bus.resp_valid, bus.resp_err, 30'd0}, 32'd0);
        check("rst/rdata", bus.resp_rdata, 32'd0);
        check("rst/ram", {ram_wr_en, ram_addr_sel, 27'd0}, 32'd0);
        check("rst/ram_addr", ram_addr, 32'd0);
        check("rst/ram_wd", ram_wr_data, 32'd0);
        rst = 1'b0;

        //   tag          we size uns addr        wdata        err rdata         sel      wr_data    stall
        txn("st_w10",     1, 2, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 0);
        txn("ld_w10",     0, 2, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'h0,        0);
        txn("ld_hs10",    0, 1, 0, 32'h10,  32'h0,        0, 32'hFFFFBEEF, 4'b0011, 32'h0,        0);
        txn("ld_hu12",    0, 1, 1, 32'h12,  32'h0,        0, 32'h0000DEAD, 4'b1100, 32'h0,        0);
        txn("ld_bs11",    0, 0, 0, 32'h11,  32'h0,        0, 32'hFFFFFFBE, 4'b0010, 32'h0,        0);
        txn("st_b23",     1, 0, 0, 32'h23,  32'h00000080, 0, 32'h0,        4'b1000, 32'h80808080, 0);
        txn("ld_bs23",    0, 0, 0, 32'h23,  32'h0,        0, 32'hFFFFFF80, 4'b1000, 32'h0,        0);
        txn("ld_bu23",    0, 0, 1, 32'h23,  32'h0,        0, 32'h00000080, 4'b1000, 32'h0,        0);
        txn("st_h42",     1, 1, 0, 32'h42,  32'h00001234, 0, 32'h0,        4'b1100, 32'h12341234, 0);
        txn("ld_hs42",    0, 1, 0, 32'h42,  32'h0,        0, 32'h00001234, 4'b1100, 32'h0,        0);
        txn("ld_w40",     0, 2, 0, 32'h40,  32'h0,        0, 32'h1234E4E5, 4'b1111, 32'h0,        0);
        txn("ld_buFF",    0, 0, 1, 32'hFF,  32'h0,        0, 32'h0000005A, 4'b1000, 32'h0,        0);
        txn("err_h41",    0, 1, 0, 32'h41,  32'h0,        1, 32'h0,        4'b0000, 32'h0,        0);
        txn("err_w06",    0, 2, 0, 32'h06,  32'h0,        1, 32'h0,        4'b0000, 32'h0,        0);
        txn("err_size3",  1, 3, 0, 32'h00,  32'h11111111, 1, 32'h0,        4'b0000, 32'h0,        0);
        txn("err_oor",    0, 0, 0, 32'h100, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        0);
        txn("err_stall",  1, 2, 0, 32'h102, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        2);
        txn("ld_stall",   0, 2, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'h0,        5);

        // Reset lands on the ACCESS edge of a store: the write still commits, the response is dropped.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h08;
        bus.req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rstacc/wr_en", 32'(ram_wr_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstacc/resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rstacc/req_ready", 32'(bus.req_ready), 32'd1);
        check("rstacc/ram", {ram_wr_en, ram_addr_sel, 27'd0}, 32'd0);
        check("rstacc/ram_wd", ram_wr_data, 32'd0);
        @(negedge clk);
        check("rstacc/no_resp", 32'(bus.resp_valid), 32'd0);
        txn("ld_w08",     0, 2, 0, 32'h08,  32'h0,        0, 32'hCAFEF00D, 4'b1111, 32'h0,        0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
